// File: rtl/warmboot_pkg.sv
// Shared types and constants for the SB_WARMBOOT sequencer.
// Image encodings match the {S1,S0} inputs of the warmboot primitive.
package warmboot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HELD  = 2'b01,
    DRAIN = 2'b10,
    BOOT  = 2'b11
  } wb_state_t;

  localparam logic [1:0] IMG_BOOTLOADER = 2'b00;
  localparam logic [1:0] IMG_USER       = 2'b01;

endpackage

// File: rtl/warmboot_sequencer_button_debounce.sv
// Two-flop synchronizer plus counting debouncer for the active-low user button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             pressed_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sample_s;

  // Synchronizer flops idle high (button released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= raw_n;
      sync2_r <= sync1_r;
    end
  end

  // Synchronized pin inverted into pressed polarity.
  always_comb begin
    sample_s = ~sync2_r;
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      pressed_r <= 1'b0;
    end else if (sample_s != pressed_r) begin
      if (cnt_r == CNT_LAST) begin
        pressed_r <= sample_s;
        cnt_r     <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/warmboot_sequencer.sv
// Arbitrates button presses against the bootloader boot command, quiesces the
// SPI flash bus and then drives the SB_WARMBOOT select and BOOT inputs.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES   = 12000,
  parameter int         LONG_PRESS_CYCLES = 12000000,
  parameter int         QUIET_CYCLES      = 16,
  parameter logic [1:0] SHORT_IMAGE       = IMG_USER,
  parameter logic [1:0] LONG_IMAGE        = IMG_BOOTLOADER
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button_n,
  input  logic       boot_cmd,
  input  logic [1:0] boot_cmd_image,
  input  logic       spi_cs,
  output logic       spi_hold,
  output logic [1:0] warm_s,
  output logic       warm_boot,
  output logic       busy
);

  localparam int HOLD_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int QUIET_W = $clog2(QUIET_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = {HOLD_W{1'b1}};
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);
  localparam logic [QUIET_W-1:0] QUIET_MAX  = {QUIET_W{1'b1}};

  wb_state_t          state_r;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [QUIET_W-1:0] quiet_cnt_r;
  logic [1:0]         image_r;
  logic               spi_hold_r;
  logic               warm_boot_r;
  logic [1:0]         warm_s_r;
  logic               busy_r;

  logic               pressed_s;
  logic               pressed_d_r;
  logic               rise_s;
  logic               fall_s;
  logic               drain_go_s;
  logic [1:0]         drain_img_s;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .raw_n   (button_n),
    .pressed (pressed_s)
  );

  // Previous debounced level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed_d_r <= 1'b0;
    end else begin
      pressed_d_r <= pressed_s;
    end
  end

  // Decide whether this cycle enters DRAIN and with which image.
  // The boot command outranks any button activity.
  always_comb begin
    rise_s      = pressed_s & ~pressed_d_r;
    fall_s      = ~pressed_s & pressed_d_r;
    drain_go_s  = 1'b0;
    drain_img_s = image_r;
    case (state_r)
      IDLE: begin
        if (boot_cmd) begin
          drain_go_s  = 1'b1;
          drain_img_s = boot_cmd_image;
        end else begin
          drain_go_s  = 1'b0;
        end
      end
      HELD: begin
        if (boot_cmd) begin
          drain_go_s  = 1'b1;
          drain_img_s = boot_cmd_image;
        end else if (hold_cnt_r == HOLD_LAST) begin
          drain_go_s  = 1'b1;
          drain_img_s = LONG_IMAGE;
        end else if (fall_s) begin
          drain_go_s  = 1'b1;
          drain_img_s = SHORT_IMAGE;
        end else begin
          drain_go_s  = 1'b0;
        end
      end
      default: begin
        drain_go_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      hold_cnt_r  <= {HOLD_W{1'b0}};
      quiet_cnt_r <= {QUIET_W{1'b0}};
      image_r     <= 2'b00;
      spi_hold_r  <= 1'b0;
      warm_boot_r <= 1'b0;
      warm_s_r    <= 2'b00;
      busy_r      <= 1'b0;
    end else if (drain_go_s) begin
      state_r     <= DRAIN;
      image_r     <= drain_img_s;
      warm_s_r    <= drain_img_s;
      quiet_cnt_r <= {QUIET_W{1'b0}};
      spi_hold_r  <= 1'b1;
      warm_boot_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r    <= HELD;
            hold_cnt_r <= {HOLD_W{1'b0}};
            busy_r     <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        HELD: begin
          if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        DRAIN: begin
          // Require an unbroken run of idle chip-select cycles.
          if (!spi_cs) begin
            quiet_cnt_r <= {QUIET_W{1'b0}};
          end else if (quiet_cnt_r == QUIET_LAST) begin
            state_r     <= BOOT;
            warm_boot_r <= 1'b1;
          end else if (quiet_cnt_r != QUIET_MAX) begin
            quiet_cnt_r <= quiet_cnt_r + {{(QUIET_W-1){1'b0}}, 1'b1};
          end else begin
            quiet_cnt_r <= quiet_cnt_r;
          end
        end
        BOOT: begin
          spi_hold_r  <= 1'b1;
          warm_boot_r <= 1'b1;
          warm_s_r    <= image_r;
          busy_r      <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          spi_hold_r  <= 1'b0;
          warm_boot_r <= 1'b0;
          warm_s_r    <= 2'b00;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign spi_hold  = spi_hold_r;
  assign warm_boot = warm_boot_r;
  assign warm_s    = warm_s_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed self-checking bench for warmboot_sequencer with short debounce,
// long-press and quiet windows.
module tb_warmboot_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       button_n;
  logic       boot_cmd;
  logic [1:0] boot_cmd_image;
  logic       spi_cs;
  logic       spi_hold;
  logic [1:0] warm_s;
  logic       warm_boot;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  warmboot_sequencer #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (50),
    .QUIET_CYCLES      (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .button_n       (button_n),
    .boot_cmd       (boot_cmd),
    .boot_cmd_image (boot_cmd_image),
    .spi_cs         (spi_cs),
    .spi_hold       (spi_hold),
    .warm_s         (warm_s),
    .warm_boot      (warm_boot),
    .busy           (busy)
  );

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    button_n       = 1'b1;
    boot_cmd       = 1'b0;
    boot_cmd_image = 2'b00;
    spi_cs         = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int t_busy;
    int t_hold;
    int t_boot;
    int n;
    logic seen;

    do_reset();
    check_value("reset_outputs", {27'd0, spi_hold, warm_boot, warm_s, busy}, 32'd0);

    // USB boot command, image 2'b10, chip select idle throughout
    boot_cmd = 1'b1; boot_cmd_image = 2'b10; spi_cs = 1'b1;
    step();
    boot_cmd = 1'b0; boot_cmd_image = 2'b00;
    check_value("cmd_hold_next", {30'd0, spi_hold, busy}, 32'd3);
    check_value("cmd_warm_s_early", {30'd0, warm_s}, 32'd2);
    step();
    check_value("cmd_boot_c1", {31'd0, warm_boot}, 32'd0);
    step();
    check_value("cmd_boot_c2", {31'd0, warm_boot}, 32'd0);
    step();
    check_value("cmd_boot_c3", {31'd0, warm_boot}, 32'd1);
    check_value("cmd_warm_s", {30'd0, warm_s}, 32'd2);

    // Reset while in BOOT clears outputs without a clock edge
    #2 reset_n = 1'b0;
    #1;
    check_value("reset_in_boot", {27'd0, spi_hold, warm_boot, warm_s, busy}, 32'd0);
    do_reset();

    // Short press: 20 cycles low
    button_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (warm_boot) seen = 1'b1;
    end
    check_value("short_no_boot_during", {31'd0, seen}, 32'd0);
    check_value("short_busy_held", {31'd0, busy}, 32'd1);
    button_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (warm_boot && n < 0) n = i;
    end
    check_value("short_boot_latency", n, 32'd10);
    check_value("short_warm_s", {30'd0, warm_s}, 32'd1);

    // Long press: 200 cycles low
    do_reset();
    button_n = 1'b0;
    t_busy = -1; t_hold = -1; t_boot = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (busy && t_busy < 0) t_busy = i;
      if (spi_hold && t_hold < 0) t_hold = i;
      if (warm_boot && t_boot < 0) t_boot = i;
    end
    check_value("long_busy_latency", t_busy, 32'd7);
    check_value("long_held_cycles", t_hold - t_busy, 32'd50);
    check_value("long_boot_before_release", t_boot, 32'd60);
    check_value("long_warm_s", {30'd0, warm_s}, 32'd0);
    button_n = 1'b1;

    // Glitch of 2 cycles never reaches the FSM
    do_reset();
    button_n = 1'b0;
    step();
    step();
    button_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy) seen = 1'b1;
    end
    check_value("glitch_busy", {31'd0, seen}, 32'd0);

    // Command during DRAIN with a broken quiet window
    do_reset();
    boot_cmd = 1'b1; boot_cmd_image = 2'b10; spi_cs = 1'b0;
    step();
    check_value("drain_entered", {31'd0, spi_hold}, 32'd1);
    boot_cmd_image = 2'b01;
    begin
      logic [5:0] cs_pat;
      logic [5:0] boot_exp;
      cs_pat   = 6'b111011;
      boot_exp = 6'b100000;
      for (int i = 0; i < 6; i++) begin
        spi_cs = cs_pat[i];
        step();
        boot_cmd = 1'b0;
        check_value($sformatf("drain_cs_%0d", i), {31'd0, warm_boot}, {31'd0, boot_exp[i]});
      end
    end
    check_value("drain_image_kept", {30'd0, warm_s}, 32'd2);

    // Reset mid-DRAIN, then a fresh sequence
    do_reset();
    boot_cmd = 1'b1; boot_cmd_image = 2'b11; spi_cs = 1'b1;
    step();
    boot_cmd = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check_value("reset_in_drain", {27'd0, spi_hold, warm_boot, warm_s, busy}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_value("post_reset_idle", {27'd0, spi_hold, warm_boot, warm_s, busy}, 32'd0);
    boot_cmd = 1'b1; boot_cmd_image = 2'b01; spi_cs = 1'b1;
    step();
    boot_cmd = 1'b0;
    check_value("rerun_hold", {31'd0, spi_hold}, 32'd1);
    step();
    step();
    check_value("rerun_boot_early", {31'd0, warm_boot}, 32'd0);
    step();
    check_value("rerun_boot", {31'd0, warm_boot}, 32'd1);
    check_value("rerun_warm_s", {30'd0, warm_s}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
